split: RTL and testbench

SPLIT -- requirements
Module: split

---
 rtl/split_pkg.sv | 13 +
 rtl/split.sv | 105 ++++++++++
 tb/tb_split.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/split_pkg.sv
// Shared types and defaults for the split chunker: FSM state encoding and parameter defaults.
package split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEF    = 16;
    localparam int CHUNK_MAX_DEF = 255;

endpackage

// File: rtl/split.sv
// Splits an accepted total into a registered stream of chunks of at most CHUNK_MAX, first chunk one cycle after accept.
// i_stall inserts a one-cycle gap; new totals accepted only in IDLE. Optional o_chunk_cnt via SPLIT_CHUNK_CNT_EN.
module split
    import split_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CHUNK_MAX = CHUNK_MAX_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_total,
    input  logic              i_stall,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done
`ifdef SPLIT_CHUNK_CNT_EN
    ,
    output logic [DATA_W-1:0] o_chunk_cnt
`endif
);

    localparam logic [DATA_W-1:0] CHUNK_LIM = DATA_W'(CHUNK_MAX);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] chunk;
    logic              accept;

    assign accept = i_valid && (state_q == IDLE);

    // The first chunk is cut straight from i_total so it lands one cycle after accept.
    assign src   = (state_q == IDLE) ? i_total : rem_q;
    assign chunk = (src > CHUNK_LIM) ? CHUNK_LIM : src;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_total == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = EMIT;
                        rem_d   = i_total;
                        if (!i_stall) begin
                            data_d = chunk;
                            rem_d  = i_total - chunk;
                        end
                    end
                end
            end
            EMIT: begin
                // A stall holds remaining, so a pending final chunk is deferred too.
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (!i_stall) begin
                    data_d = chunk;
                    rem_d  = rem_q - chunk;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    assign o_data  = data_q;
    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);

`ifdef SPLIT_CHUNK_CNT_EN
    logic [DATA_W-1:0] cnt_q, cnt_d;

    assign cnt_d = (accept ? '0 : cnt_q) + DATA_W'(data_d != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_chunk_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_split.sv
// Directed per-cycle vector table for split, plus a long 0xFFFF transaction checked by accumulation.
module tb_split;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [15:0] total;
    logic        stall;
    logic [15:0] data;
    logic        busy;
    logic        done;
`ifdef SPLIT_CHUNK_CNT_EN
    logic [15:0] chunk_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    split #(.DATA_W(16), .CHUNK_MAX(255)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .o_ready (ready),
        .i_total (total),
        .i_stall (stall),
        .o_data  (data),
        .o_busy  (busy),
        .o_done  (done)
`ifdef SPLIT_CHUNK_CNT_EN
        ,
        .o_chunk_cnt (chunk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per cycle: inputs driven in that cycle, outputs expected in that same cycle.
    typedef struct {
        logic        v;
        logic [15:0] t;
        logic        s;
        logic        r;
        logic [15:0] d;
        logic        rdy;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [15:0] t, input logic s, input logic r,
                       input logic [15:0] d, input logic rdy, input logic bsy, input logic dn);
        vec_t x;
        x.v = v; x.t = t; x.s = s; x.r = r;
        x.d = d; x.rdy = rdy; x.bsy = bsy; x.dn = dn;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int chunks;
        int sum;
        int bad_chunk;
        int dones;
        int cyc;
        logic seen_done;

        rst = 1'b1; valid = 1'b0; total = '0; stall = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // 600, no stall: 255, 255, 90, done, ready
        add(1, 600, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0,  90, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // total of zero: straight to DONE
        add(1, 0, 0, 0,   0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // 600 with stall in T+1
        add(1, 600, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0,  90, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // valid of 7 during EMIT is ignored
        add(1, 600, 0, 0, 0, 1, 0, 0);
        add(1, 7, 0, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0,  90, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // 300: stall coincides with the final chunk, which is deferred
        add(1, 300, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0,  45, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // 255 accepted with stall: exactly one CHUNK_MAX chunk, one cycle late
        add(1, 255, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 1, 0);
        add(0, 0, 0, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // 256: just over the limit
        add(1, 256, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 255, 0, 1, 0);
        add(0, 0, 0, 0,   1, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        // reset after the first chunk aborts without done, then 10 runs cleanly
        add(1, 600, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 255, 0, 1, 0);
        add(0, 0, 0, 0,   0, 1, 0, 0);
        add(1, 10, 0, 0,  0, 1, 0, 0);
        add(0, 0, 0, 0,  10, 0, 1, 0);
        add(0, 0, 0, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0,   0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid = vecs[i].v;
            total = vecs[i].t;
            stall = vecs[i].s;
            rst   = vecs[i].r;
            tests++;
            if (data !== vecs[i].d || ready !== vecs[i].rdy ||
                busy !== vecs[i].bsy || done !== vecs[i].dn) begin
                failed++;
                $display("FAIL row%0d: data=%0d ready=%0b busy=%0b done=%0b expected data=%0d ready=%0b busy=%0b done=%0b",
                         i, data, ready, busy, done,
                         vecs[i].d, vecs[i].rdy, vecs[i].bsy, vecs[i].dn);
            end
        end

`ifdef SPLIT_CHUNK_CNT_EN
        // the 10 transaction left one chunk counted
        check("cnt_after_10", {16'd0, chunk_cnt}, 32'd1);
`endif

        // 0xFFFF: 257 chunks of 255 then a single done
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; valid = 1'b1; total = 16'hFFFF;
        @(negedge clk);
        valid = 1'b0; total = '0;
        chunks = 0; sum = 0; bad_chunk = 0; dones = 0; cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (done) begin
                seen_done = 1'b1;
                dones++;
                if (data !== 16'd0) bad_chunk++;
`ifdef SPLIT_CHUNK_CNT_EN
                check("cnt_at_done", {16'd0, chunk_cnt}, 32'd257);
`endif
            end else if (data != 16'd0) begin
                chunks++;
                sum += int'(data);
                if (data !== 16'd255) bad_chunk++;
            end else begin
                bad_chunk++;
            end
            cyc++;
            @(negedge clk);
        end
        check("big_done_seen", {31'd0, seen_done}, 32'd1);
        check("big_chunks",    chunks, 32'd257);
        check("big_sum",       sum, 32'd65535);
        check("big_bad_chunk", bad_chunk, 32'd0);
        check("big_ready",     {31'd0, ready}, 32'd1);
        check("big_busy",      {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("big_no_2nd_done", {31'd0, done}, 32'd0);
`ifdef SPLIT_CHUNK_CNT_EN
        check("cnt_held_idle", {16'd0, chunk_cnt}, 32'd257);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
